// File: rtl/dense_layer_par_if.sv
// Read ports of the X, W and B RAMs and the Y RAM write port.
// The master side is the layer engine; the slave side is the memory.
interface dense_layer_par_if #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int XA    = 4,
    parameter int WA    = 8,
    parameter int GA    = 4,
    parameter int YA    = 6
);
    logic                  x_cs;
    logic [XA-1:0]         x_addr;
    logic [DW-1:0]         x_dout;
    logic                  w_cs;
    logic [WA-1:0]         w_addr;
    logic [LANES*DW-1:0]   w_dout;
    logic                  b_cs;
    logic [GA-1:0]         b_addr;
    logic [LANES*DW-1:0]   b_dout;
    logic                  y_cs;
    logic                  y_we;
    logic [YA-1:0]         y_addr;
    logic [DW-1:0]         y_din;

    modport master (
        output x_cs, x_addr, input x_dout,
        output w_cs, w_addr, input w_dout,
        output b_cs, b_addr, input b_dout,
        output y_cs, y_we, y_addr, y_din
    );

    modport slave (
        input x_cs, x_addr, output x_dout,
        input w_cs, w_addr, output w_dout,
        input b_cs, b_addr, output b_dout,
        input y_cs, y_we, y_addr, y_din
    );
endinterface

// File: rtl/dense_layer_par.sv
// Fully-connected layer engine: LANES neurons per group, rounded and
// saturated requantisation, linear / ReLU / leaky-ReLU output.
module dense_layer_par #(
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int ACC_W   = 40,
    parameter int LANES   = 4,
    parameter int MAX_IN  = 16,
    parameter int MAX_OUT = 64,
    localparam int XA = $clog2(MAX_IN),
    localparam int GA = $clog2((MAX_OUT + LANES - 1) / LANES),
    localparam int WA = $clog2(MAX_IN * ((MAX_OUT + LANES - 1) / LANES)),
    localparam int YA = $clog2(MAX_OUT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XA:0]     cfg_in_size,
    input  logic [YA:0]     cfg_out_size,
    input  logic [1:0]      act_sel,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            sat,
    dense_layer_par_if.master ram
);

    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic signed [ACC_W-1:0] YMAX =
        {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] YMIN =
        {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HALF =
        ACC_W'(1) << (FRAC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MAC, S_POST, S_WRITE, S_DONE
    } state_t;

    state_t state, nxt;

    logic [XA:0]    in_sz;
    logic [XA:0]    c;
    logic [YA:0]    out_sz;
    logic [1:0]     act;
    logic [GA-1:0]  g;
    logic [WA-1:0]  w_base;
    logic [YA-1:0]  y_base;
    logic [KW-1:0]  k;

    logic signed [ACC_W-1:0] acc [LANES];
    logic signed [DW-1:0]    yv  [LANES];

    logic signed [2*DW-1:0]  prod  [LANES];
    logic signed [ACC_W-1:0] pext  [LANES];
    logic signed [ACC_W-1:0] bext  [LANES];
    logic signed [ACC_W-1:0] rnd   [LANES];
    logic signed [DW-1:0]    sv    [LANES];
    logic signed [DW-1:0]    post  [LANES];
    logic                    any_clip;

    logic          cfg_bad;
    logic [YA-1:0] y_idx;
    logic          last_lane;
    logic          last_out;
    logic          c_last;

    assign cfg_bad = (cfg_in_size == '0)
                  || (cfg_in_size > (XA+1)'(MAX_IN))
                  || (cfg_out_size == '0)
                  || (cfg_out_size > (YA+1)'(MAX_OUT));

    assign y_idx     = y_base + YA'(k);
    assign last_lane = (k == KW'(LANES - 1));
    assign last_out  = ({1'b0, y_idx} == out_sz - 1'b1);
    assign c_last    = (c == in_sz - 1'b1);

    // Per-lane product, bias alignment and requantisation.
    always_comb begin
        any_clip = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            prod[l] = $signed(ram.x_dout) * $signed(ram.w_dout[l*DW +: DW]);
            pext[l] = {{(ACC_W-2*DW){prod[l][2*DW-1]}}, prod[l]};
            bext[l] = {{(ACC_W-DW){ram.b_dout[l*DW+DW-1]}},
                       ram.b_dout[l*DW +: DW]} <<< FRAC;
            rnd[l]  = (acc[l] + HALF) >>> FRAC;
            sv[l]   = rnd[l][DW-1:0];
            if (rnd[l] > YMAX) begin
                sv[l]    = YMAX[DW-1:0];
                any_clip = 1'b1;
            end else if (rnd[l] < YMIN) begin
                sv[l]    = YMIN[DW-1:0];
                any_clip = 1'b1;
            end
            post[l] = sv[l];
            if (act == 2'd1 && sv[l] < 0) post[l] = '0;
            if (act == 2'd2 && sv[l] < 0) post[l] = sv[l] >>> 3;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next state and RAM strobes.
    always_comb begin
        nxt        = state;
        busy       = 1'b0;
        done       = 1'b0;
        ram.x_cs   = 1'b0;
        ram.x_addr = '0;
        ram.w_cs   = 1'b0;
        ram.w_addr = '0;
        ram.b_cs   = 1'b0;
        ram.b_addr = '0;
        ram.y_cs   = 1'b0;
        ram.y_we   = 1'b0;
        ram.y_addr = '0;
        ram.y_din  = '0;
        unique case (state)
            S_IDLE: begin
                if (start) nxt = cfg_bad ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                ram.b_cs   = 1'b1;
                ram.b_addr = g;
                ram.x_cs   = 1'b1;
                ram.w_cs   = 1'b1;
                ram.w_addr = w_base;
                nxt        = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (c_last) begin
                    nxt = S_POST;
                end else begin
                    ram.x_cs   = 1'b1;
                    ram.x_addr = XA'(c + 1'b1);
                    ram.w_cs   = 1'b1;
                    ram.w_addr = w_base + WA'(c + 1'b1);
                end
            end
            S_POST: begin
                busy = 1'b1;
                nxt  = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                ram.y_cs   = 1'b1;
                ram.y_we   = 1'b1;
                ram.y_addr = y_idx;
                ram.y_din  = yv[k];
                if (last_out)       nxt = S_DONE;
                else if (last_lane) nxt = S_LOAD;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Config latch, counters, accumulators and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sz  <= '0;
            out_sz <= '0;
            act    <= '0;
            c      <= '0;
            g      <= '0;
            k      <= '0;
            w_base <= '0;
            y_base <= '0;
            sat    <= 1'b0;
            err    <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= '0;
                yv[l]  <= '0;
            end
        end else begin
            err <= (state == S_IDLE) && start && cfg_bad;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        in_sz  <= cfg_in_size;
                        out_sz <= cfg_out_size;
                        act    <= act_sel;
                        sat    <= 1'b0;
                        g      <= '0;
                        w_base <= '0;
                        y_base <= '0;
                    end
                end
                S_LOAD: begin
                    c <= '0;
                    k <= '0;
                end
                S_MAC: begin
                    c <= c + 1'b1;
                    for (int l = 0; l < LANES; l++)
                        acc[l] <= ((c == '0) ? bext[l] : acc[l]) + pext[l];
                end
                S_POST: begin
                    for (int l = 0; l < LANES; l++) yv[l] <= post[l];
                    if (any_clip) sat <= 1'b1;
                end
                S_WRITE: begin
                    k <= k + 1'b1;
                    if (last_lane && !last_out) begin
                        g      <= g + 1'b1;
                        w_base <= w_base + WA'(in_sz);
                        y_base <= y_base + YA'(LANES);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
